alu: RTL and testbench

//  Single-cycle MIPS-style integer ALU for the CPU execute stage. Decodes a full 32-bit

---
 rtl/alu_pkg.sv | 128 ++++++++++++
 rtl/alu_shifter.sv | 39 +++
 rtl/alu.sv | 106 ++++++++++
 tb/tb_alu.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared decode tables for the execute-stage ALU: opcode/funct codes, flag bit positions,
// and the instruction decoder that turns opcode/funct into datapath controls.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_LESS = 1;
  localparam int FLAG_OVF  = 0;

  typedef enum logic [1:0] {
    SH_LEFT,
    SH_LOGIC,
    SH_ARITH
  } shift_op_e;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SHIFT
  } alu_fn_e;

  typedef enum logic [1:0] {
    SRC_REG,
    SRC_SIMM,
    SRC_ZIMM
  } src_e;

  typedef struct packed {
    alu_fn_e   fn;
    src_e      src;
    logic      ovf_en;
    logic      zero_en;
    logic      var_shamt;
    shift_op_e sh_op;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c.fn        = ALU_NONE;
    c.src       = SRC_REG;
    c.ovf_en    = 1'b0;
    c.zero_en   = 1'b0;
    c.var_shamt = 1'b0;
    c.sh_op     = SH_LEFT;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          F_ADD:  begin c.fn = ALU_ADD; c.ovf_en = 1'b1; end
          F_ADDU: c.fn = ALU_ADD;
          F_SUB:  begin c.fn = ALU_SUB; c.ovf_en = 1'b1; end
          F_SUBU: c.fn = ALU_SUB;
          F_AND:  c.fn = ALU_AND;
          F_OR:   c.fn = ALU_OR;
          F_XOR:  c.fn = ALU_XOR;
          F_NOR:  c.fn = ALU_NOR;
          F_SLT:  c.fn = ALU_SLT;
          F_SLTU: c.fn = ALU_SLTU;
          F_SLL:  begin c.fn = ALU_SHIFT; c.sh_op = SH_LEFT;  end
          F_SRL:  begin c.fn = ALU_SHIFT; c.sh_op = SH_LOGIC; end
          F_SRA:  begin c.fn = ALU_SHIFT; c.sh_op = SH_ARITH; end
          F_SLLV: begin c.fn = ALU_SHIFT; c.sh_op = SH_LEFT;  c.var_shamt = 1'b1; end
          F_SRLV: begin c.fn = ALU_SHIFT; c.sh_op = SH_LOGIC; c.var_shamt = 1'b1; end
          F_SRAV: begin c.fn = ALU_SHIFT; c.sh_op = SH_ARITH; c.var_shamt = 1'b1; end
          default: c.fn = ALU_NONE;
        endcase
      end
      OPC_ADDI:  begin c.fn = ALU_ADD; c.src = SRC_SIMM; c.ovf_en = 1'b1; end
      OPC_ADDIU: begin c.fn = ALU_ADD; c.src = SRC_SIMM; end
      OPC_SLTI:  begin c.fn = ALU_SLT; c.src = SRC_SIMM; end
      // sltiu compares against the zero-extended immediate, unlike classic MIPS
      OPC_SLTIU: begin c.fn = ALU_SLTU; c.src = SRC_ZIMM; end
      OPC_ANDI:  begin c.fn = ALU_AND; c.src = SRC_ZIMM; end
      OPC_ORI:   begin c.fn = ALU_OR;  c.src = SRC_ZIMM; end
      OPC_XORI:  begin c.fn = ALU_XOR; c.src = SRC_ZIMM; end
      OPC_BEQ, OPC_BNE: begin c.fn = ALU_SUB; c.zero_en = 1'b1; end
      OPC_LW, OPC_SW:   begin c.fn = ALU_ADD; c.src = SRC_SIMM; end
      default: c.fn = ALU_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [XLEN-1:0] reverse_bits(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = v[XLEN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// 32-bit log-stage barrel shifter (left / logical right / arithmetic right), combinational.
// The amount is a full 32-bit value; anything >= 32 saturates to all-fill.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] data,
  input  logic [XLEN-1:0] amount,
  input  shift_op_e       op,
  output logic [XLEN-1:0] shifted
);

  logic            fill;
  logic            saturate;
  logic [XLEN-1:0] stage;
  logic [XLEN-1:0] fill_mask;

  assign fill     = (op == SH_ARITH) ? data[XLEN-1] : 1'b0;
  assign saturate = |amount[XLEN-1:5];

  // Left shifts reuse the right-shift stages on a bit-reversed operand.
  always_comb begin
    stage     = (op == SH_LEFT) ? reverse_bits(data) : data;
    fill_mask = '0;
    for (int i = 0; i < 5; i++) begin
      if (amount[i]) begin
        fill_mask = fill ? ~({XLEN{1'b1}} >> (1 << i)) : '0;
        stage     = (stage >> (1 << i)) | fill_mask;
      end
    end
    if (saturate) begin
      shifted = {XLEN{fill}};
    end else if (op == SH_LEFT) begin
      shifted = reverse_bits(stage);
    end else begin
      shifted = stage;
    end
  end

endmodule

// File: rtl/alu.sv
// Single-cycle MIPS-style integer ALU: combinational result/flags (0 cycles) plus a
// registered copy (1 cycle). No handshake; it accepts a new instruction every cycle.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] reg_A,
  input  logic [XLEN-1:0] reg_B,
  output logic [XLEN-1:0] result,
  output logic [2:0]      flags,
  output logic [XLEN-1:0] result_q,
  output logic [2:0]      flags_q
);

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [4:0]      shamt;
  logic [15:0]     imm;
  logic            unused_fields;
  ctrl_t           ctrl;

  logic [XLEN-1:0] simm;
  logic [XLEN-1:0] zimm;
  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            add_ovf;
  logic            sub_ovf;
  logic            lt_signed;
  logic            lt_unsigned;
  logic [XLEN-1:0] shift_amount;
  logic [XLEN-1:0] shifted;

  assign opcode        = instruction[31:26];
  assign funct         = instruction[5:0];
  assign shamt         = instruction[10:6];
  assign imm           = instruction[15:0];
  // Register specifiers are resolved upstream; the ALU only sees the operand values.
  assign unused_fields = ^instruction[25:16];

  assign ctrl = decode(opcode, funct);

  assign simm = {{16{imm[15]}}, imm};
  assign zimm = {16'h0000, imm};

  always_comb begin
    case (ctrl.src)
      SRC_SIMM: operand_b = simm;
      SRC_ZIMM: operand_b = zimm;
      default:  operand_b = reg_B;
    endcase
  end

  assign sum  = reg_A + operand_b;
  assign diff = reg_A - operand_b;

  assign add_ovf = (reg_A[XLEN-1] == operand_b[XLEN-1]) && (sum[XLEN-1]  != reg_A[XLEN-1]);
  assign sub_ovf = (reg_A[XLEN-1] != operand_b[XLEN-1]) && (diff[XLEN-1] != reg_A[XLEN-1]);

  assign lt_signed   = $signed(reg_A) < $signed(operand_b);
  assign lt_unsigned = reg_A < operand_b;

  // Variable shifts take the whole rs value so large amounts saturate instead of wrapping.
  assign shift_amount = ctrl.var_shamt ? reg_A : {27'd0, shamt};

  alu_shifter u_shifter (
    .data    (reg_B),
    .amount  (shift_amount),
    .op      (ctrl.sh_op),
    .shifted (shifted)
  );

  always_comb begin
    result = '0;
    flags  = 3'b000;
    case (ctrl.fn)
      ALU_ADD:   result = sum;
      ALU_SUB:   result = diff;
      ALU_AND:   result = reg_A & operand_b;
      ALU_OR:    result = reg_A | operand_b;
      ALU_XOR:   result = reg_A ^ operand_b;
      ALU_NOR:   result = ~(reg_A | operand_b);
      ALU_SLT:   result = {31'd0, lt_signed};
      ALU_SLTU:  result = {31'd0, lt_unsigned};
      ALU_SHIFT: result = shifted;
      default:   result = '0;
    endcase
    flags[FLAG_ZERO] = ctrl.zero_en && (reg_A == reg_B);
    flags[FLAG_LESS] = ((ctrl.fn == ALU_SLT) || (ctrl.fn == ALU_SLTU)) && result[0];
    flags[FLAG_OVF]  = ctrl.ovf_en &&
                       (((ctrl.fn == ALU_ADD) && add_ovf) || ((ctrl.fn == ALU_SUB) && sub_ovf));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= 3'b000;
    end else begin
      result_q <= result;
      flags_q  <= flags;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: literal expectations plus a behavioural model checked every cycle.
`timescale 1ns/1ps
module tb_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic [31:0] reg_A = 32'h0;
  logic [31:0] reg_B = 32'h0;
  logic [31:0] result;
  logic [2:0]  flags;
  logic [31:0] result_q;
  logic [2:0]  flags_q;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_rq = 32'h0;
  logic [2:0]  exp_fq = 3'b000;

  alu dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .reg_A       (reg_A),
    .reg_B       (reg_B),
    .result      (result),
    .flags       (flags),
    .result_q    (result_q),
    .flags_q     (flags_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] sh);
    return {6'h00, 5'h0A, 5'h0B, 5'h0C, sh, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'h15, 5'h0A, imm};
  endfunction

  // Reference semantics in plain 64-bit integer arithmetic.
  task automatic model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [2:0] f);
    longint sa, sb, simm, s, sbsh;
    longint unsigned ua, ub, uz, amt;
    logic [5:0] op, fn;
    logic [15:0] imm;
    op = ins[31:26]; fn = ins[5:0]; imm = ins[15:0];
    sa = longint'($signed(a)); sb = longint'($signed(b)); simm = longint'($signed(imm));
    ua = longint'(a); ub = longint'(b); uz = longint'(imm);
    r = 32'h0; f = 3'b000; s = 0;
    if (op == 6'h00) begin
      amt = (fn == 6'h04 || fn == 6'h06 || fn == 6'h07) ? ua : longint'(ins[10:6]);
      case (fn)
        6'h20, 6'h21: begin s = sa + sb; r = s[31:0];
                        if (fn == 6'h20 && (s > 64'sd2147483647 || s < -64'sd2147483648)) f[0] = 1'b1; end
        6'h22, 6'h23: begin s = sa - sb; r = s[31:0];
                        if (fn == 6'h22 && (s > 64'sd2147483647 || s < -64'sd2147483648)) f[0] = 1'b1; end
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: begin r = (sa < sb) ? 32'd1 : 32'd0; f[1] = r[0]; end
        6'h2B: begin r = (ua < ub) ? 32'd1 : 32'd0; f[1] = r[0]; end
        6'h00, 6'h04: r = (amt >= 32) ? 32'h0 : 32'(ub << amt);
        6'h02, 6'h06: r = (amt >= 32) ? 32'h0 : 32'(ub >> amt);
        6'h03, 6'h07: begin sbsh = sb >>> ((amt >= 32) ? 63 : amt); r = sbsh[31:0]; end
        default: r = 32'h0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin s = sa + simm; r = s[31:0];
                        if (op == 6'h08 && (s > 64'sd2147483647 || s < -64'sd2147483648)) f[0] = 1'b1; end
        6'h0A: begin r = (sa < simm) ? 32'd1 : 32'd0; f[1] = r[0]; end
        6'h0B: begin r = (ua < uz) ? 32'd1 : 32'd0; f[1] = r[0]; end
        6'h0C: r = a & {16'h0, imm};
        6'h0D: r = a | {16'h0, imm};
        6'h0E: r = a ^ {16'h0, imm};
        6'h04, 6'h05: begin s = sa - sb; r = s[31:0]; f[2] = (a == b); end
        6'h23, 6'h2B: begin s = sa + simm; r = s[31:0]; end
        default: r = 32'h0;
      endcase
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, got, want);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] got, input logic [2:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %03b expected %03b", name, got, want);
    end
  endtask

  // Registered-output expectation: cleared by reset, otherwise the model of the inputs at the edge.
  always @(posedge clk or posedge rst) begin
    logic [31:0] mr;
    logic [2:0]  mf;
    if (rst) begin
      exp_rq <= 32'h0;
      exp_fq <= 3'b000;
    end else begin
      model(instruction, reg_A, reg_B, mr, mf);
      exp_rq <= mr;
      exp_fq <= mf;
    end
  end

  always @(negedge clk) begin
    logic [31:0] mr;
    logic [2:0]  mf;
    model(instruction, reg_A, reg_B, mr, mf);
    check32("model result", result, mr);
    check3("model flags", flags, mf);
    check32("model result_q", result_q, exp_rq);
    check3("model flags_q", flags_q, exp_fq);
  end

  task automatic vec(input string name, input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic [2:0] ef);
    logic [31:0] mr;
    logic [2:0]  mf;
    @(posedge clk);
    #2;
    instruction = ins; reg_A = a; reg_B = b;
    #1;
    check32({name, " result"}, result, er);
    check3({name, " flags"}, flags, ef);
    model(ins, a, b, mr, mf);
    check32({name, " model pin"}, mr, er);
    check3({name, " model pin flags"}, mf, ef);
  endtask

  initial begin
    instruction = rt(6'h20, 5'd0); reg_A = 32'd1; reg_B = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    check32("reset result_q", result_q, 32'h0);
    check3("reset flags_q", flags_q, 3'b000);
    check32("comb during reset", result, 32'h3);
    @(negedge clk);
    rst = 1'b0;

    vec("add ovf",     rt(6'h20, 0), 32'h00000003, 32'h7FFFFFFF, 32'h80000002, 3'b001);
    vec("addu",        rt(6'h21, 0), 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 3'b000);
    vec("add neg ovf", rt(6'h20, 0), 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 3'b001);
    vec("sub ovf",     rt(6'h22, 0), 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 3'b001);
    vec("sub eq",      rt(6'h22, 0), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b000);
    vec("subu",        rt(6'h23, 0), 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 3'b000);
    vec("and",         rt(6'h24, 0), 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 3'b000);
    vec("or",          rt(6'h25, 0), 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0, 3'b000);
    vec("xor",         rt(6'h26, 0), 32'hF0F0FF00, 32'h0FF0F0F0, 32'hFF000FF0, 3'b000);
    vec("nor",         rt(6'h27, 0), 32'hF0F0FF00, 32'h0FF0F0F0, 32'h000F000F, 3'b000);
    vec("slt",         rt(6'h2A, 0), 32'h80000003, 32'h7FFFFFFF, 32'h00000001, 3'b010);
    vec("sltu",        rt(6'h2B, 0), 32'h80000003, 32'h7FFFFFFF, 32'h00000000, 3'b000);
    vec("sll",         rt(6'h00, 2), 32'h00000000, 32'hC0000003, 32'h0000000C, 3'b000);
    vec("srl",         rt(6'h02, 4), 32'h00000000, 32'h80000000, 32'h08000000, 3'b000);
    vec("sra",         rt(6'h03, 16), 32'h00000000, 32'hC0000003, 32'hFFFFC000, 3'b000);
    vec("sllv",        rt(6'h04, 0), 32'h00000008, 32'hC0000003, 32'h00000300, 3'b000);
    vec("srlv 31",     rt(6'h06, 0), 32'h0000001F, 32'h80000000, 32'h00000001, 3'b000);
    vec("sllv 32",     rt(6'h04, 0), 32'h00000020, 32'hFFFFFFFF, 32'h00000000, 3'b000);
    vec("srav big",    rt(6'h07, 0), 32'h40000008, 32'h40000003, 32'h00000000, 3'b000);
    vec("srav 32 neg", rt(6'h07, 0), 32'h00000020, 32'h80000000, 32'hFFFFFFFF, 3'b000);
    vec("bad funct",   rt(6'h01, 3), 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 3'b000);
    vec("addi wrap",   it(6'h08, 16'h0001), 32'hFFFFFFFF, 32'h0, 32'h00000000, 3'b000);
    vec("addi ovf",    it(6'h08, 16'h0001), 32'h7FFFFFFF, 32'h0, 32'h80000000, 3'b001);
    vec("addiu",       it(6'h09, 16'h0001), 32'h7FFFFFFF, 32'h0, 32'h80000000, 3'b000);
    vec("slti",        it(6'h0A, 16'h0002), 32'h00000001, 32'h0, 32'h00000001, 3'b010);
    vec("slti neg",    it(6'h0A, 16'hFFFF), 32'hFFFFFFFF, 32'h0, 32'h00000000, 3'b000);
    vec("sltiu zext",  it(6'h0B, 16'h8001), 32'h0000C000, 32'h0, 32'h00000000, 3'b000);
    vec("sltiu lt",    it(6'h0B, 16'h0001), 32'h00000000, 32'h0, 32'h00000001, 3'b010);
    vec("andi",        it(6'h0C, 16'h8000), 32'hFFFFFFFF, 32'h0, 32'h00008000, 3'b000);
    vec("ori",         it(6'h0D, 16'h8000), 32'h00000000, 32'h0, 32'h00008000, 3'b000);
    vec("xori",        it(6'h0E, 16'hFFFF), 32'h12345678, 32'h0, 32'h1234A987, 3'b000);
    vec("beq eq",      it(6'h04, 16'h0010), 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3'b100);
    vec("beq ne",      it(6'h04, 16'h0010), 32'h00000005, 32'h00000006, 32'hFFFFFFFF, 3'b000);
    vec("bne",         it(6'h05, 16'h0010), 32'hBFFFFFFF, 32'hFFFFFFFF, 32'hC0000000, 3'b000);
    vec("lw",          it(6'h23, 16'h0001), 32'hDDDDDDDD, 32'h0, 32'hDDDDDDDE, 3'b000);
    vec("sw",          it(6'h2B, 16'hFFFC), 32'h00000100, 32'h0, 32'h000000FC, 3'b000);
    vec("bad opcode",  it(6'h3F, 16'h1234), 32'h11111111, 32'h22222222, 32'h00000000, 3'b000);

    // Mid-run reset: registered copy clears at once and reloads on the first edge after release.
    vec("pre-rst add", rt(6'h20, 0), 32'h00000003, 32'h7FFFFFFF, 32'h80000002, 3'b001);
    @(posedge clk);
    #1;
    check32("held result_q", result_q, 32'h80000002);
    check3("held flags_q", flags_q, 3'b001);
    rst = 1'b1;
    #1;
    check32("async rst result_q", result_q, 32'h0);
    check3("async rst flags_q", flags_q, 3'b000);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check32("post-rst result_q", result_q, 32'h80000002);
    check3("post-rst flags_q", flags_q, 3'b001);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
